// File: rtl/mem_port_arbiter_if.sv
// Bundle between the fetch/load-store requesters, the arbiter and the shared memory port.
// slave is the arbiter's view; master is the requesters' and memory's combined view.
interface mem_port_arbiter_if #(
  parameter int unsigned XLEN = 32
);
  typedef logic [1:0] write_width_t;

  logic              if_req;
  logic [XLEN-1:0]   if_addr;
  logic              if_ready;
  logic              if_r_valid;
  logic [XLEN-1:0]   if_r_data;

  logic              d_req;
  logic [XLEN-1:0]   d_addr;
  logic [XLEN-1:0]   d_w_data;
  write_width_t      d_w_width;
  logic              d_w_enable;
  logic              d_ready;
  logic              d_r_valid;
  logic [XLEN-1:0]   d_r_data;

  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_w_data;
  write_width_t      mem_w_width;
  logic              mem_w_enable;
  logic [XLEN-1:0]   mem_r_data;

  modport slave (
    input  if_req, if_addr, d_req, d_addr, d_w_data, d_w_width, d_w_enable, mem_r_data,
    output if_ready, if_r_valid, if_r_data, d_ready, d_r_valid, d_r_data,
           mem_addr, mem_w_data, mem_w_width, mem_w_enable
  );

  modport master (
    output if_req, if_addr, d_req, d_addr, d_w_data, d_w_width, d_w_enable, mem_r_data,
    input  if_ready, if_r_valid, if_r_data, d_ready, d_r_valid, d_r_data,
           mem_addr, mem_w_data, mem_w_width, mem_w_enable
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store; data has priority.
// Define MEM_ARB_FAIRNESS_EN to add the starvation limiter that forces fetch through.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic             clock,
  input logic             reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {OwnNone, OwnIf, OwnData} owner_e;

  owner_e rd_owner;
  logic   grant_if;
  logic   grant_d;
  logic   force_if;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be in 1..15");
  end

`ifdef MEM_ARB_FAIRNESS_EN
  logic [3:0] starve_cnt;

  assign force_if = bus.if_req & bus.d_req & (starve_cnt == 4'(STARVE_LIMIT));

  // Counts data grants that left a fetch waiting; the forced grant caps it at the limit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (grant_if || !bus.if_req) begin
      starve_cnt <= 4'd0;
    end else if (grant_d) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // Grants are masked during reset so nothing reaches the port.
  assign grant_d  = bus.d_req & ~force_if & ~reset;
  assign grant_if = bus.if_req & ~grant_d & ~reset;

  assign bus.if_ready     = grant_if;
  assign bus.d_ready      = grant_d;
  assign bus.mem_addr     = grant_if ? bus.if_addr : bus.d_addr;
  assign bus.mem_w_data   = grant_if ? '0 : bus.d_w_data;
  assign bus.mem_w_enable = grant_d & bus.d_w_enable;
  assign bus.mem_w_width  = bus.d_w_width;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_owner <= OwnNone;
    end else if (grant_if) begin
      rd_owner <= OwnIf;
    end else if (grant_d && !bus.d_w_enable) begin
      rd_owner <= OwnData;
    end else begin
      rd_owner <= OwnNone;
    end
  end

  assign bus.if_r_valid = (rd_owner == OwnIf) & ~reset;
  assign bus.d_r_valid  = (rd_owner == OwnData) & ~reset;
  assign bus.if_r_data  = bus.mem_r_data;
  assign bus.d_r_data   = bus.mem_r_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; expectations follow MEM_ARB_FAIRNESS_EN when defined.
module tb_mem_port_arbiter;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  mem_port_arbiter_if #(.XLEN(32)) bus ();

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req     = 1'b0;
    bus.if_addr    = 32'h0;
    bus.d_req      = 1'b0;
    bus.d_addr     = 32'h0;
    bus.d_w_data   = 32'h0;
    bus.d_w_width  = 2'b00;
    bus.d_w_enable = 1'b0;
    bus.mem_r_data = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    bus.if_req = 1'b1;
    bus.d_req  = 1'b1;
    bus.d_w_enable = 1'b1;
    step();
    #1;
    checks++; if (bus.if_ready !== 1'b0) begin errors++; $display("FAIL reset_if_ready got=%b want=0", bus.if_ready); end
    checks++; if (bus.d_ready !== 1'b0) begin errors++; $display("FAIL reset_d_ready got=%b want=0", bus.d_ready); end
    checks++; if (bus.mem_w_enable !== 1'b0) begin errors++; $display("FAIL reset_w_enable got=%b want=0", bus.mem_w_enable); end
    checks++; if (bus.if_r_valid !== 1'b0 || bus.d_r_valid !== 1'b0) begin errors++; $display("FAIL reset_valids got=%b%b want=00", bus.if_r_valid, bus.d_r_valid); end
    idle_inputs();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_fetch();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0010;
    #1;
    checks++; if (bus.if_ready !== 1'b1 || bus.d_ready !== 1'b0) begin errors++; $display("FAIL fetch_grant got if=%b d=%b want if=1 d=0", bus.if_ready, bus.d_ready); end
    checks++; if (bus.mem_addr !== 32'h0000_0010) begin errors++; $display("FAIL fetch_addr got=%h want=00000010", bus.mem_addr); end
    step();
    bus.if_req     = 1'b0;
    bus.mem_r_data = 32'hDEAD_BEEF;
    #1;
    checks++; if (bus.if_r_valid !== 1'b1 || bus.d_r_valid !== 1'b0) begin errors++; $display("FAIL fetch_valid got if=%b d=%b want if=1 d=0", bus.if_r_valid, bus.d_r_valid); end
    checks++; if (bus.if_r_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fetch_data got=%h want=deadbeef", bus.if_r_data); end
    step();
    #1;
    checks++; if (bus.if_r_valid !== 1'b0) begin errors++; $display("FAIL fetch_valid_once got=%b want=0", bus.if_r_valid); end
  endtask

  task automatic test_data_read();
    idle_inputs();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0014;
    bus.d_req   = 1'b1;
    bus.d_addr  = 32'h0002_0004;
    #1;
    checks++; if (bus.d_ready !== 1'b1 || bus.if_ready !== 1'b0) begin errors++; $display("FAIL dread_grant got d=%b if=%b want d=1 if=0", bus.d_ready, bus.if_ready); end
    checks++; if (bus.mem_addr !== 32'h0002_0004) begin errors++; $display("FAIL dread_addr got=%h want=00020004", bus.mem_addr); end
    step();
    bus.d_req      = 1'b0;
    bus.mem_r_data = 32'hCAFE_F00D;
    #1;
    checks++; if (bus.d_r_valid !== 1'b1 || bus.if_r_valid !== 1'b0) begin errors++; $display("FAIL dread_valid got d=%b if=%b want d=1 if=0", bus.d_r_valid, bus.if_r_valid); end
    checks++; if (bus.d_r_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL dread_data got=%h want=cafef00d", bus.d_r_data); end
    checks++; if (bus.if_ready !== 1'b1 || bus.mem_addr !== 32'h0000_0014) begin errors++; $display("FAIL dread_fetch_next got ready=%b addr=%h want ready=1 addr=00000014", bus.if_ready, bus.mem_addr); end
    step();
    bus.if_req = 1'b0;
    #1;
    checks++; if (bus.if_r_valid !== 1'b1 || bus.d_r_valid !== 1'b0) begin errors++; $display("FAIL dread_fetch_valid got if=%b d=%b want if=1 d=0", bus.if_r_valid, bus.d_r_valid); end
    step();
  endtask

  task automatic test_store();
    idle_inputs();
    bus.if_req     = 1'b1;
    bus.if_addr    = 32'h0000_0018;
    bus.d_req      = 1'b1;
    bus.d_addr     = 32'h0002_0008;
    bus.d_w_data   = 32'h1234_5678;
    bus.d_w_width  = 2'b10;
    bus.d_w_enable = 1'b1;
    #1;
    checks++; if (bus.d_ready !== 1'b1 || bus.if_ready !== 1'b0) begin errors++; $display("FAIL store_grant got d=%b if=%b want d=1 if=0", bus.d_ready, bus.if_ready); end
    checks++; if (bus.mem_w_enable !== 1'b1 || bus.mem_w_data !== 32'h1234_5678) begin errors++; $display("FAIL store_port got we=%b wd=%h want we=1 wd=12345678", bus.mem_w_enable, bus.mem_w_data); end
    checks++; if (bus.mem_addr !== 32'h0002_0008 || bus.mem_w_width !== 2'b10) begin errors++; $display("FAIL store_addr got addr=%h w=%b want addr=00020008 w=10", bus.mem_addr, bus.mem_w_width); end
    step();
    idle_inputs();
    #1;
    checks++; if (bus.if_r_valid !== 1'b0 || bus.d_r_valid !== 1'b0) begin errors++; $display("FAIL store_no_valid got if=%b d=%b want 0 0", bus.if_r_valid, bus.d_r_valid); end
    step();
  endtask

  task automatic test_port_mux();
    idle_inputs();
    bus.if_req     = 1'b1;
    bus.if_addr    = 32'h0000_0040;
    bus.d_addr     = 32'h0003_0000;
    bus.d_w_data   = 32'hFFFF_0000;
    bus.d_w_width  = 2'b01;
    bus.d_w_enable = 1'b1;
    #1;
    checks++; if (bus.mem_w_data !== 32'h0 || bus.mem_w_enable !== 1'b0) begin errors++; $display("FAIL mux_fetch got wd=%h we=%b want wd=00000000 we=0", bus.mem_w_data, bus.mem_w_enable); end
    checks++; if (bus.mem_w_width !== 2'b01) begin errors++; $display("FAIL mux_width got=%b want=01", bus.mem_w_width); end
    step();
    bus.if_req = 1'b0;
    #1;
    checks++; if (bus.mem_addr !== 32'h0003_0000 || bus.mem_w_enable !== 1'b0) begin errors++; $display("FAIL mux_idle got addr=%h we=%b want addr=00030000 we=0", bus.mem_addr, bus.mem_w_enable); end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_starvation();
    logic [5:0] exp_if;
`ifdef MEM_ARB_FAIRNESS_EN
    exp_if = 6'b010000;  // cycle index 4 is the forced fetch
`else
    exp_if = 6'b000000;
`endif
    idle_inputs();
    bus.if_req = 1'b1;
    bus.d_req  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (bus.if_ready !== exp_if[i] || bus.d_ready !== !exp_if[i]) begin
        errors++;
        $display("FAIL starve_cycle%0d got if=%b d=%b want if=%b d=%b", i, bus.if_ready,
                 bus.d_ready, exp_if[i], !exp_if[i]);
      end
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    bus.d_req   = 1'b1;
    bus.d_addr  = 32'h0002_0100;
    bus.if_addr = 32'h0000_0100;
    #1;
    checks++; if (bus.d_ready !== 1'b1) begin errors++; $display("FAIL b2b_d_grant got=%b want=1", bus.d_ready); end
    step();
    bus.d_req  = 1'b0;
    bus.if_req = 1'b1;
    #1;
    checks++; if (bus.if_ready !== 1'b1 || bus.d_r_valid !== 1'b1) begin errors++; $display("FAIL b2b_overlap1 got ready=%b valid=%b want 1 1", bus.if_ready, bus.d_r_valid); end
    step();
    bus.if_req = 1'b0;
    bus.d_req  = 1'b1;
    #1;
    checks++; if (bus.d_ready !== 1'b1 || bus.if_r_valid !== 1'b1 || bus.d_r_valid !== 1'b0) begin errors++; $display("FAIL b2b_overlap2 got ready=%b ifv=%b dv=%b want 1 1 0", bus.d_ready, bus.if_r_valid, bus.d_r_valid); end
    step();
    idle_inputs();
    #1;
    checks++; if (bus.d_r_valid !== 1'b1 || bus.if_r_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail got dv=%b ifv=%b want 1 0", bus.d_r_valid, bus.if_r_valid); end
    step();
  endtask

  task automatic test_reset_inflight();
    idle_inputs();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0200;
    #1;
    checks++; if (bus.if_ready !== 1'b1) begin errors++; $display("FAIL inflight_grant got=%b want=1", bus.if_ready); end
    step();
    reset     = 1'b1;
    bus.d_req = 1'b1;
    #1;
    checks++; if (bus.if_r_valid !== 1'b0) begin errors++; $display("FAIL inflight_dropped got=%b want=0", bus.if_r_valid); end
    checks++; if (bus.if_ready !== 1'b0 || bus.d_ready !== 1'b0) begin errors++; $display("FAIL inflight_readies got if=%b d=%b want 0 0", bus.if_ready, bus.d_ready); end
    step();
    checks++; if (bus.if_r_valid !== 1'b0 || bus.d_r_valid !== 1'b0) begin errors++; $display("FAIL inflight_hold got if=%b d=%b want 0 0", bus.if_r_valid, bus.d_r_valid); end
    reset     = 1'b0;
    bus.d_req = 1'b0;
    #1;
    checks++; if (bus.if_ready !== 1'b1 || bus.mem_addr !== 32'h0000_0200) begin errors++; $display("FAIL inflight_regrant got ready=%b addr=%h want 1 00000200", bus.if_ready, bus.mem_addr); end
    step();
    bus.if_req     = 1'b0;
    bus.mem_r_data = 32'h0BAD_F00D;
    #1;
    checks++; if (bus.if_r_valid !== 1'b1 || bus.if_r_data !== 32'h0BAD_F00D) begin errors++; $display("FAIL inflight_after got v=%b d=%h want 1 0badf00d", bus.if_r_valid, bus.if_r_data); end
    step();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_fetch();
    test_data_read();
    test_store();
    test_port_mux();
    test_starvation();
    test_back_to_back();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
